// File: rtl/bicubic_tap_mac_pipe_if.sv
// Handshake bundle for bicubic_tap_mac_pipe.
// Input side: in_valid/in_ready, per-transaction clamp mode, N_TAP weights and
// N_TAP x N_CH sign-magnitude pixels. Output side: out_valid/out_ready,
// N_CH output magnitudes and N_CH sign bits.
// slave = the MAC pipe, master = the upstream/downstream environment.
interface bicubic_tap_mac_pipe_if #(
  parameter int unsigned N_TAP = 4,
  parameter int unsigned N_CH  = 4,
  parameter int unsigned PW    = 8,
  parameter int unsigned WW    = 8
);
  logic                            in_valid;
  logic                            in_ready;
  logic                            in_mode_clamp;
  logic [N_TAP*WW-1:0]             in_weight;
  logic [N_TAP*N_CH*(PW+1)-1:0]    in_pixel;
  logic                            out_valid;
  logic                            out_ready;
  logic [N_CH*PW-1:0]              out_pixel;
  logic [N_CH-1:0]                 out_sign;

  modport master (
    output in_valid, in_mode_clamp, in_weight, in_pixel, out_ready,
    input  in_ready, out_valid, out_pixel, out_sign
  );

  modport slave (
    input  in_valid, in_mode_clamp, in_weight, in_pixel, out_ready,
    output in_ready, out_valid, out_pixel, out_sign
  );
endinterface

// File: rtl/bicubic_tap_mac_pipe.sv
// Three-stage pipelined weighted tap reduction for the bicubic datapath.
// Per transaction and channel: dot product of N_TAP signed weights with N_TAP
// sign-magnitude pixels, then round-half-up, shift by FRAC and saturate to PW
// bits, as sign-magnitude or clamped-to-zero depending on in_mode_clamp.
// Ports: clk, rst (async, active-high); bus = slave side of
// bicubic_tap_mac_pipe_if (valid/ready in and out, full backpressure).
// Stages: S1 products, S2 channel sums, S3 output register.
module bicubic_tap_mac_pipe #(
  parameter int unsigned N_TAP = 4,
  parameter int unsigned N_CH  = 4,
  parameter int unsigned PW    = 8,
  parameter int unsigned WW    = 8,
  parameter int unsigned FRAC  = 6
) (
  input logic                   clk,
  input logic                   rst,
  bicubic_tap_mac_pipe_if.slave bus
);
  localparam int unsigned PXW = PW + 2;
  localparam int unsigned PRW = WW + PW + 2;
  localparam int unsigned SW  = PRW + $clog2(N_TAP);
  // One extra bit so adding the rounding constant can never wrap.
  localparam int unsigned RW  = SW + 1;
  localparam int unsigned NP  = N_TAP * N_CH;

  localparam logic signed [RW-1:0] Rnd    = RW'(2 ** (FRAC - 1));
  localparam logic signed [RW-1:0] MaxMag = RW'(2 ** PW - 1);

  // Sign-magnitude to two's complement; -0 maps to 0.
  function automatic logic signed [PXW-1:0] sm_to_signed(input logic [PW:0] p);
    logic signed [PXW-1:0] m;
    m = signed'({2'b00, p[PW-1:0]});
    return p[PW] ? -m : m;
  endfunction

  function automatic logic signed [PRW-1:0] mul(input logic signed [WW-1:0]  w,
                                                input logic signed [PXW-1:0] p);
    logic signed [PRW-1:0] a, b;
    a = PRW'(w);
    b = PRW'(p);
    return a * b;
  endfunction

  logic              s1_valid_q, s1_valid_d, s1_mode_q, s1_mode_d;
  logic [NP*PRW-1:0] s1_prod_q, s1_prod_d;
  logic              s2_valid_q, s2_valid_d, s2_mode_q, s2_mode_d;
  logic [N_CH*SW-1:0] s2_sum_q, s2_sum_d;
  logic              s3_valid_q, s3_valid_d;
  logic [N_CH*PW-1:0] out_pixel_q, out_pixel_d;
  logic [N_CH-1:0]   out_sign_q, out_sign_d;

  logic s1_load, s2_load, s3_load, in_fire;
  logic signed [SW-1:0] acc;
  logic signed [RW-1:0] r, r_abs;
  logic                 r_neg;

  // A stage loads when empty or when its contents move on this cycle, so
  // bubbles collapse and a stall only freezes full stages.
  assign s3_load      = ~s3_valid_q | bus.out_ready;
  assign s2_load      = ~s2_valid_q | s3_load;
  assign s1_load      = ~s1_valid_q | s2_load;
  assign bus.in_ready = s1_load & ~rst;
  assign in_fire      = bus.in_valid & bus.in_ready;

  always_comb begin
    s1_valid_d = s1_load ? in_fire : s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_prod_d  = s1_prod_q;
    if (in_fire) begin
      s1_mode_d = bus.in_mode_clamp;
      for (int t = 0; t < N_TAP; t++) begin
        for (int c = 0; c < N_CH; c++) begin
          s1_prod_d[(t*N_CH+c)*PRW +: PRW] =
            mul(bus.in_weight[t*WW +: WW],
                sm_to_signed(bus.in_pixel[(t*N_CH+c)*(PW+1) +: PW+1]));
        end
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
    s2_mode_d  = s2_mode_q;
    s2_sum_d   = s2_sum_q;
    acc        = '0;
    if (s2_load && s1_valid_q) begin
      s2_mode_d = s1_mode_q;
      for (int c = 0; c < N_CH; c++) begin
        acc = '0;
        for (int t = 0; t < N_TAP; t++) begin
          acc = acc + SW'($signed(s1_prod_q[(t*N_CH+c)*PRW +: PRW]));
        end
        s2_sum_d[c*SW +: SW] = acc;
      end
    end
  end

  always_comb begin
    s3_valid_d  = s3_load ? s2_valid_q : s3_valid_q;
    out_pixel_d = out_pixel_q;
    out_sign_d  = out_sign_q;
    r           = '0;
    r_abs       = '0;
    r_neg       = 1'b0;
    if (s3_load && s2_valid_q) begin
      for (int c = 0; c < N_CH; c++) begin
        // Arithmetic shift after adding half an LSB: round half toward +inf.
        r     = (RW'($signed(s2_sum_q[c*SW +: SW])) + Rnd) >>> FRAC;
        r_neg = r[RW-1];
        r_abs = r_neg ? -r : r;
        if (r_neg && s2_mode_q) begin
          out_pixel_d[c*PW +: PW] = '0;
          out_sign_d[c]           = 1'b0;
        end else begin
          out_pixel_d[c*PW +: PW] = (r_abs > MaxMag) ? {PW{1'b1}} : r_abs[PW-1:0];
          out_sign_d[c]           = r_neg;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= 1'b0;
      s1_prod_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_mode_q   <= 1'b0;
      s2_sum_q    <= '0;
      s3_valid_q  <= 1'b0;
      out_pixel_q <= '0;
      out_sign_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      s1_prod_q   <= s1_prod_d;
      s2_valid_q  <= s2_valid_d;
      s2_mode_q   <= s2_mode_d;
      s2_sum_q    <= s2_sum_d;
      s3_valid_q  <= s3_valid_d;
      out_pixel_q <= out_pixel_d;
      out_sign_q  <= out_sign_d;
    end
  end

  assign bus.out_valid = s3_valid_q;
  assign bus.out_pixel = out_pixel_q;
  assign bus.out_sign  = out_sign_q;
endmodule

// File: tb/tb_bicubic_tap_mac_pipe.sv
module tb_bicubic_tap_mac_pipe;
  localparam int N_TAP = 4;
  localparam int N_CH  = 4;
  localparam int PW    = 8;
  localparam int WW    = 8;
  localparam int FRAC  = 6;
  localparam int TWV   = N_TAP * WW;
  localparam int PXV   = N_TAP * N_CH * (PW + 1);
  localparam int OPV   = N_CH * PW;

  typedef struct packed {
    logic [OPV-1:0]  pix;
    logic [N_CH-1:0] sgn;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  res_t exp_q[$];
  int   acc_q[$];

  bicubic_tap_mac_pipe_if #(.N_TAP(N_TAP), .N_CH(N_CH), .PW(PW), .WW(WW)) bus ();

  bicubic_tap_mac_pipe #(
    .N_TAP(N_TAP), .N_CH(N_CH), .PW(PW), .WW(WW), .FRAC(FRAC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model in plain integer arithmetic.
  function automatic res_t model(input logic [TWV-1:0] w, input logic [PXV-1:0] px,
                                 input logic m);
    res_t res;
    int   s, p, q;
    res = '0;
    for (int c = 0; c < N_CH; c++) begin
      s = 0;
      for (int t = 0; t < N_TAP; t++) begin
        p = int'(px[(t*N_CH+c)*(PW+1) +: PW]);
        if (px[(t*N_CH+c)*(PW+1)+PW]) p = -p;
        s += int'($signed(w[t*WW +: WW])) * p;
      end
      q = (s + (1 << (FRAC - 1))) >>> FRAC;
      if (q < 0) begin
        if (!m) begin
          res.sgn[c]          = 1'b1;
          res.pix[c*PW +: PW] = (-q > 255) ? 8'hFF : 8'(-q);
        end
      end else begin
        res.pix[c*PW +: PW] = (q > 255) ? 8'hFF : 8'(q);
      end
    end
    return res;
  endfunction

  function automatic logic [TWV-1:0] pack_w(input int w0, input int w1, input int w2,
                                            input int w3);
    return {8'(w3), 8'(w2), 8'(w1), 8'(w0)};
  endfunction

  function automatic logic [PXV-1:0] put_px(input logic [PXV-1:0] v, input int t,
                                            input int c, input logic [PW:0] p);
    logic [PXV-1:0] o;
    o = v;
    o[(t*N_CH+c)*(PW+1) +: PW+1] = p;
    return o;
  endfunction

  function automatic logic [PXV-1:0] rand_px();
    logic [PXV-1:0] v;
    for (int i = 0; i < N_TAP * N_CH; i++) v[i*(PW+1) +: PW+1] = 9'($urandom);
    return v;
  endfunction

  // Driver: called at posedge+1; holds the transaction until accepted, records
  // expected result and accept cycle, returns at posedge+1 after the accept edge.
  task automatic send(input logic [TWV-1:0] w, input logic [PXV-1:0] px, input logic m,
                      input res_t e);
    int g;
    bus.in_weight     = w;
    bus.in_pixel      = px;
    bus.in_mode_clamp = m;
    bus.in_valid      = 1'b1;
    #1;
    g = 0;
    while (!bus.in_ready && g < 50) begin
      @(posedge clk); #2; g++;
    end
    if (g >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed %0b for %0d cycles, required 1", bus.in_ready, g);
    end
    exp_q.push_back(e);
    acc_q.push_back(cyc);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid);
    end
    n_tests++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b, required 0", bus.in_ready);
    end
    n_tests++;
    if (bus.out_pixel !== '0 || bus.out_sign !== '0) begin
      n_fail++;
      $display("FAIL reset_data: pixel %h sign %b, required 0", bus.out_pixel, bus.out_sign);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_in_ready: got %b, required 1", bus.in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_identity();
    logic [PXV-1:0] px;
    res_t e;
    int   g, a;
    px = '0;
    px = put_px(px, 1, 0, 9'd200);
    px = put_px(px, 1, 1, 9'd17);
    px = put_px(px, 1, 2, 9'd0);
    px = put_px(px, 1, 3, 9'd255);
    e.pix = {8'd255, 8'd0, 8'd17, 8'd200};
    e.sgn = 4'b0000;
    bus.out_ready = 1'b1;
    send(pack_w(0, 64, 0, 0), px, 1'b0, e);
    g = 0;
    while (!bus.out_valid && g < 20) begin @(posedge clk); #1; g++; end
    a = acc_q.pop_front();
    e = exp_q.pop_front();
    n_tests++;
    if (cyc - a != 3) begin
      n_fail++; $display("FAIL identity_latency: got %0d cycles, required 3", cyc - a);
    end
    n_tests++;
    if (bus.out_pixel !== e.pix || bus.out_sign !== e.sgn) begin
      n_fail++;
      $display("FAIL identity_data: got %h/%b, required %h/%b", bus.out_pixel, bus.out_sign,
               e.pix, e.sgn);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cubic();
    logic [PXV-1:0] px;
    res_t e;
    int   g;
    px = '0;
    for (int t = 0; t < N_TAP; t++)
      for (int c = 0; c < N_CH; c++) px = put_px(px, t, c, 9'd128);
    e.pix = {4{8'd128}};
    e.sgn = 4'b0000;
    send(pack_w(-4, 36, 36, -4), px, 1'b0, e);
    g = 0;
    while (!bus.out_valid && g < 20) begin @(posedge clk); #1; g++; end
    void'(acc_q.pop_front());
    e = exp_q.pop_front();
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_pixel !== e.pix || bus.out_sign !== e.sgn) begin
      n_fail++;
      $display("FAIL cubic_data: got v%b %h/%b, required %h/%b", bus.out_valid, bus.out_pixel,
               bus.out_sign, e.pix, e.sgn);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [PXV-1:0] px;
    res_t e0, e1, e;
    int   g, a;
    px = '0;
    px = put_px(px, 0, 0, 9'd255);
    px = put_px(px, 3, 0, 9'd255);
    e0.pix = {8'd0, 8'd0, 8'd0, 8'd32};
    e0.sgn = 4'b0001;
    e1.pix = '0;
    e1.sgn = 4'b0000;
    send(pack_w(-4, 36, 36, -4), px, 1'b0, e0);
    send(pack_w(-4, 36, 36, -4), px, 1'b1, e1);
    for (int k = 0; k < 2; k++) begin
      g = 0;
      while (!bus.out_valid && g < 20) begin @(posedge clk); #1; g++; end
      a = acc_q.pop_front();
      e = exp_q.pop_front();
      n_tests++;
      if (cyc - a != 3) begin
        n_fail++; $display("FAIL b2b_latency[%0d]: got %0d, required 3", k, cyc - a);
      end
      n_tests++;
      if (bus.out_pixel !== e.pix || bus.out_sign !== e.sgn) begin
        n_fail++;
        $display("FAIL b2b_negative[%0d]: got %h/%b, required %h/%b", k, bus.out_pixel,
                 bus.out_sign, e.pix, e.sgn);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    logic [PXV-1:0] px;
    res_t e0, e1, e;
    int   g;
    px = '0;
    px = put_px(px, 1, 0, 9'h0FF);
    px = put_px(px, 2, 0, 9'h0FF);
    px = put_px(px, 1, 1, 9'h1FF);
    px = put_px(px, 2, 1, 9'h1FF);
    px = put_px(px, 1, 2, 9'h100);  // negative zero
    e0.pix = {8'd0, 8'd0, 8'd255, 8'd255};
    e0.sgn = 4'b0010;
    e1.pix = {8'd0, 8'd0, 8'd0, 8'd255};
    e1.sgn = 4'b0000;
    send(pack_w(0, 100, 100, 0), px, 1'b0, e0);
    send(pack_w(0, 100, 100, 0), px, 1'b1, e1);
    for (int k = 0; k < 2; k++) begin
      g = 0;
      while (!bus.out_valid && g < 20) begin @(posedge clk); #1; g++; end
      void'(acc_q.pop_front());
      e = exp_q.pop_front();
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_pixel !== e.pix || bus.out_sign !== e.sgn) begin
        n_fail++;
        $display("FAIL saturation[%0d]: got v%b %h/%b, required %h/%b", k, bus.out_valid,
                 bus.out_pixel, bus.out_sign, e.pix, e.sgn);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [TWV-1:0] w;
    logic [PXV-1:0] px;
    logic           m, stall_prev, exp_rdy;
    logic [OPV-1:0] pix_prev;
    logic [N_CH-1:0] sgn_prev;
    res_t           e;
    int             sent, got, budget;
    sent = 0; got = 0; budget = 0;
    stall_prev = 1'b0; pix_prev = '0; sgn_prev = '0;
    w = TWV'($urandom); px = rand_px(); m = 1'($urandom_range(0, 1));
    while (got < 8 && budget < 300) begin
      bus.out_ready = (budget % 2 == 0);
      if (sent < 8 && $urandom_range(0, 3) != 0) begin
        bus.in_valid = 1'b1; bus.in_weight = w; bus.in_pixel = px; bus.in_mode_clamp = m;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      exp_rdy = !(exp_q.size() == 3 && !bus.out_ready);
      n_tests++;
      if (bus.in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL bp_in_ready: got %b, required %b (occupancy %0d)", bus.in_ready, exp_rdy,
                 exp_q.size());
      end
      if (stall_prev) begin
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_pixel !== pix_prev || bus.out_sign !== sgn_prev) begin
          n_fail++;
          $display("FAIL bp_stall_stable: got v%b %h/%b, required v1 %h/%b", bus.out_valid,
                   bus.out_pixel, bus.out_sign, pix_prev, sgn_prev);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL bp_unexpected: got output %h, required none", bus.out_pixel);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_pixel !== e.pix || bus.out_sign !== e.sgn) begin
            n_fail++;
            $display("FAIL bp_data[%0d]: got %h/%b, required %h/%b", got, bus.out_pixel,
                     bus.out_sign, e.pix, e.sgn);
          end
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(w, px, m));
        sent++;
        w = TWV'($urandom); px = rand_px(); m = 1'($urandom_range(0, 1));
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      pix_prev   = bus.out_pixel;
      sgn_prev   = bus.out_sign;
      @(posedge clk); #1;
      budget++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n_tests++;
    if (got != 8 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_count: got %0d outputs (%0d left), required 8 (0 left)", got,
               exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [PXV-1:0] px;
    res_t e;
    logic stale;
    int   g, a;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      px = rand_px();
      send(TWV'($urandom), px, 1'b0, '0);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_pixel !== '0 ||
        bus.out_sign !== '0) begin
      n_fail++;
      $display("FAIL midreset_clear: valid %b ready %b pixel %h sign %b, required 0/0/0/0",
               bus.out_valid, bus.in_ready, bus.out_pixel, bus.out_sign);
    end
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    stale = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.out_valid) stale = 1'b1;
    end
    n_tests++;
    if (stale !== 1'b0) begin
      n_fail++; $display("FAIL midreset_stale: got out_valid after release, required none");
    end
    px = put_px('0, 1, 2, 9'd99);
    e.pix = {8'd0, 8'd99, 8'd0, 8'd0};
    e.sgn = 4'b0000;
    send(pack_w(0, 64, 0, 0), px, 1'b0, e);
    g = 0;
    while (!bus.out_valid && g < 20) begin @(posedge clk); #1; g++; end
    a = acc_q.pop_front();
    e = exp_q.pop_front();
    n_tests++;
    if (cyc - a != 3) begin
      n_fail++; $display("FAIL midreset_latency: got %0d, required 3", cyc - a);
    end
    n_tests++;
    if (bus.out_pixel !== e.pix || bus.out_sign !== e.sgn) begin
      n_fail++;
      $display("FAIL midreset_data: got %h/%b, required %h/%b", bus.out_pixel, bus.out_sign,
               e.pix, e.sgn);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst               = 1'b1;
    bus.in_valid      = 1'b0;
    bus.in_mode_clamp = 1'b0;
    bus.in_weight     = '0;
    bus.in_pixel      = '0;
    bus.out_ready     = 1'b1;
    test_reset();
    test_identity();
    test_cubic();
    test_back_to_back();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
